// File: rtl/fifo_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_scheduler
// Purpose  : Access scheduler in front of an 8-entry synchronous FIFO. Two
//            writers and one reader share the FIFO. At most one transfer is
//            granted per cycle: round-robin between the writers, alternation
//            between write and read. The chosen command is registered onto the
//            FIFO command inputs. A shadow occupancy count blocks writes when
//            full and reads when empty, so the FIFO never sees an illegal op.
// Ports    : clk, reset_n (async, active low), clear (sync flush)
//            wr_req0/1, wr_data0/1, rd_req       - requester side
//            wr_gnt0/1, rd_gnt                   - combinational grants
//            fifo_wr_en/rd_en/opclear, fifo_din  - registered FIFO commands
//            count, full, empty, cmd_state       - status
// Options  : FIFO_SCHED_RD_PRIORITY_EN - when defined, a legal read always
//            beats a pending write and the write/read turn bit is removed.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_scheduler #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wr_req0,
  input  logic                  wr_req1,
  input  logic [DATA_WIDTH-1:0] wr_data0,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  input  logic                  rd_req,
  output logic                  wr_gnt0,
  output logic                  wr_gnt1,
  output logic                  rd_gnt,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  output logic                  fifo_opclear,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            cmd_state
);

  localparam logic [1:0] ST_NOP   = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_READ  = 2'b10;
  localparam logic [1:0] ST_CLEAR = 2'b11;

  logic [1:0]            cmd_state_q, cmd_state_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  rr_q, rr_d;
`ifndef FIFO_SCHED_RD_PRIORITY_EN
  logic                  turn_q, turn_d;
`endif

  logic full_w, empty_w;
  logic wr_pend, rd_pend;   // a legal write candidate / legal read exists
  logic wr_sel;             // which writer would be served
  logic do_wr, do_rd;       // the single transfer chosen this cycle

  assign full_w  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty_w = (count_q == '0);

  assign wr_pend = (wr_req0 | wr_req1) & ~full_w & ~clear;
  assign rd_pend = rd_req & ~empty_w & ~clear;
  // With a single requester it is served regardless of the pointer.
  assign wr_sel  = (wr_req0 & wr_req1) ? rr_q : wr_req1;

`ifdef FIFO_SCHED_RD_PRIORITY_EN
  assign do_rd = rd_pend;
  assign do_wr = wr_pend & ~rd_pend;
`else
  // turn only arbitrates when both kinds are legal this cycle.
  assign do_wr = wr_pend & (~rd_pend | ~turn_q);
  assign do_rd = rd_pend & (~wr_pend | turn_q);
`endif

  assign wr_gnt0 = do_wr & ~wr_sel;
  assign wr_gnt1 = do_wr &  wr_sel;
  assign rd_gnt  = do_rd;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_state_q <= ST_NOP;
      count_q     <= '0;
      din_q       <= '0;
      rr_q        <= 1'b0;
`ifndef FIFO_SCHED_RD_PRIORITY_EN
      turn_q      <= 1'b0;
`endif
    end else begin
      cmd_state_q <= cmd_state_d;
      count_q     <= count_d;
      din_q       <= din_d;
      rr_q        <= rr_d;
`ifndef FIFO_SCHED_RD_PRIORITY_EN
      turn_q      <= turn_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    cmd_state_d = ST_NOP;
    count_d     = count_q;
    din_d       = din_q;
    rr_d        = rr_q;
`ifndef FIFO_SCHED_RD_PRIORITY_EN
    turn_d      = turn_q;
`endif
    if (clear) begin
      cmd_state_d = ST_CLEAR;
      count_d     = '0;
    end else if (do_wr) begin
      cmd_state_d = ST_WRITE;
      count_d     = count_q + CNT_WIDTH'(1);
      din_d       = wr_sel ? wr_data1 : wr_data0;
      rr_d        = ~wr_sel;
`ifndef FIFO_SCHED_RD_PRIORITY_EN
      turn_d      = 1'b1;
`endif
    end else if (do_rd) begin
      cmd_state_d = ST_READ;
      count_d     = count_q - CNT_WIDTH'(1);
`ifndef FIFO_SCHED_RD_PRIORITY_EN
      turn_d      = 1'b0;
`endif
    end
  end

  // Output decode
  always_comb begin
    fifo_wr_en   = (cmd_state_q == ST_WRITE);
    fifo_rd_en   = (cmd_state_q == ST_READ);
    fifo_opclear = (cmd_state_q == ST_CLEAR);
  end

  assign fifo_din  = din_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign cmd_state = cmd_state_q;

endmodule
`default_nettype wire
